// File: rtl/flag_evt_pkg.sv
// rtl/flag_evt_pkg.sv - shared defaults and entry type for the flag event logger
package flag_evt_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 8;

  // One logged event is just the cycle-counter value captured at detection time.
  typedef logic [TS_W_DEF-1:0] evt_entry_t;

endpackage

// File: rtl/flag_evt_fifo.sv
// rtl/flag_evt_fifo.sv - synchronous FIFO holding event timestamps
module flag_evt_fifo
  import flag_evt_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = evt_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  entry_t           mem [DEPTH];
  entry_t           hold;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             accept;
  logic             do_pop;

  assign full   = (count == LVL_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || do_pop);
  assign level  = count;
  // While empty, keep showing the last popped value so the head output never glitches.
  assign head_data = empty ? hold : mem[rd_ptr];

  // Storage array; write-only on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks pushes minus pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      case ({accept, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flag_evt_logger.sv
// rtl/flag_evt_logger.sv - timestamps detection pulses into a FIFO with drop accounting
module flag_evt_logger
  import flag_evt_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag_in,
  input  logic                     clr_ovf,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TS_W-1:0] ts_cnt;
  logic            full;
  logic            empty;
  logic            drop;

  // An event is lost only when the FIFO is full and the consumer is not draining this cycle.
  assign drop      = flag_in && full && !out_ready;
  assign out_valid = !empty;

  flag_evt_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (logic [TS_W-1:0])
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (flag_in),
    .push_data (ts_cnt),
    .pop       (out_ready),
    .head_data (out_ts),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Free-running timestamp source, wraps from all-ones to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Sticky overflow and saturating drop count; a drop wins over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != CNT_MAX) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flag_evt_logger.sv
// tb/tb_flag_evt_logger.sv - randomized self-checking bench for flag_evt_logger
module tb_flag_evt_logger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flag_in = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_ts;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [15:0] m_ts;
  logic [15:0] q[$];
  bit          m_ovf;
  int          m_cnt;

  flag_evt_logger dut (
    .clk       (clk),
    .rst       (rst),
    .flag_in   (flag_in),
    .clr_ovf   (clr_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ts    (out_ts),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ts  = 16'h0000;
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model, return at the following negedge.
  task automatic cycle(input bit f, input bit r, input bit c);
    bit did_drop;
    flag_in   = f;
    out_ready = r;
    clr_ovf   = c;
    did_drop  = 1'b0;
    if (r && q.size() > 0) void'(q.pop_front());
    if (f) begin
      if (q.size() < DEPTH) q.push_back(m_ts);
      else did_drop = 1'b1;
    end
    if (did_drop) begin
      m_ovf = 1'b1;
      m_cnt = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (c) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    m_ts = m_ts + 16'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flag_in = 1'b1;
    out_ready = 1'b1;
    clr_ovf = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    flag_in = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_ts !== 16'h0000) begin errors++; $display("FAIL reset_ts got %0h exp 0", out_ts); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    while (m_ts != 16'd5) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", out_valid); end
    checks++; if (out_ts !== 16'd5) begin errors++; $display("FAIL single_ts got %0h exp 5", out_ts); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1 got %0d exp 1", level); end
    cycle(1'b0, 1'b1, 1'b0);
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level0 got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %0b exp 0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    while (m_ts != 16'd10) cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_ts !== 16'(10 + i)) begin errors++; $display("FAIL ovf_entry%0d got %0d exp %0d", i, out_ts, 10 + i); end
      cycle(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] tail_ts;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    tail_ts = m_ts;
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fpp_level got %0d exp 4", level); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL fpp_drop got %0d exp 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %0b exp 0", overflow); end
    checks++; if (out_ts !== 16'd1) begin errors++; $display("FAIL fpp_head got %0d exp 1", out_ts); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    checks++; if (out_ts !== tail_ts) begin errors++; $display("FAIL fpp_tail got %0d exp %0d", out_ts, tail_ts); end
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    while (m_ts != 16'hFFFE) begin
      flag_in = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
      m_ts = m_ts + 16'd1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL wrap_level got %0d exp 3", level); end
    checks++; if (out_ts !== 16'hFFFE) begin errors++; $display("FAIL wrap_ts0 got %0h exp fffe", out_ts); end
    cycle(1'b0, 1'b1, 1'b0);
    checks++; if (out_ts !== 16'hFFFF) begin errors++; $display("FAIL wrap_ts1 got %0h exp ffff", out_ts); end
    cycle(1'b0, 1'b1, 1'b0);
    checks++; if (out_ts !== 16'h0000) begin errors++; $display("FAIL wrap_ts2 got %0h exp 0000", out_ts); end
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4 + 300; i++) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop got %0d exp 255", drop_cnt); end
    cycle(1'b1, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clrdrop_ovf got %0b exp 1", overflow); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clrdrop_cnt got %0d exp 1", drop_cnt); end
    cycle(1'b0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b exp 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    checks++; if (level !== 3'd3 || out_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL arst_pre got lvl %0d v %0b o %0b exp 3 1 1", level, out_valid, overflow);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b exp 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d exp 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got %0b exp 0", overflow); end
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (out_ts !== 16'h0000 || out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_first_ts got %0h v %0b exp 0 1", out_ts, out_valid);
    end
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit f, r, c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      f = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) != 0);
      c = ($urandom_range(0, 15) == 0);
      cycle(f, r, c);
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d got %0b exp %0b", i, out_valid, q.size() != 0); end
      checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level@%0d got %0d exp %0d", i, level, q.size()); end
      if (q.size() != 0) begin
        checks++; if (out_ts !== q[0]) begin errors++; $display("FAIL rnd_ts@%0d got %0h exp %0h", i, out_ts, q[0]); end
      end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d got %0b exp %0b", i, overflow, m_ovf); end
      checks++; if (drop_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_drop@%0d got %0d exp %0d", i, drop_cnt, m_cnt); end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_saturate();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
